// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Queue entries pair a word address with the instruction read from it.
package ifetch_pkg;

    localparam int unsigned QDEPTH    = 4;
    localparam int unsigned MEM_WORDS = 64;
    localparam int unsigned PC_W      = $clog2(MEM_WORDS);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } qentry_t;

    // Encodings for 0/1/2 instructions moved per cycle (pop and enqueue counts)
    localparam logic [1:0] POP_NONE = 2'd0;
    localparam logic [1:0] POP_ONE  = 2'd1;
    localparam logic [1:0] POP_TWO  = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue with two write ports and two read ports.
// Dequeue is clipped to the valid entries, enqueue to the free slots before the pop.
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = QDEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [1:0]               enq_cnt,
    input  logic [31:0]              enq0_pc,
    input  logic [31:0]              enq0_inst,
    input  logic [31:0]              enq1_pc,
    input  logic [31:0]              enq1_inst,
    input  logic [1:0]               deq_cnt,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              head0_pc,
    output logic [31:0]              head0_inst,
    output logic [31:0]              head1_pc,
    output logic [31:0]              head1_inst
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    qentry_t         mem_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, head_nx, tail_nx;
    logic [CntW-1:0] count_q, count_d, free, n_deq, n_enq;
    qentry_t         head0, head1;

    assign head_nx = head_q + PtrW'(1);
    assign tail_nx = tail_q + PtrW'(1);

    always_comb begin
        free  = CntW'(DEPTH) - count_q;
        n_deq = (deq_cnt > POP_TWO) ? CntW'(2) : CntW'(deq_cnt);
        if (n_deq > count_q) begin
            n_deq = count_q;
        end
        n_enq = (enq_cnt > POP_TWO) ? CntW'(2) : CntW'(enq_cnt);
        if (n_enq > free) begin
            n_enq = free;
        end
        head_d  = head_q + PtrW'(n_deq);
        tail_d  = tail_q + PtrW'(n_enq);
        count_d = count_q - n_deq + n_enq;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (!flush && n_enq >= CntW'(1)) begin
                mem_q[tail_q] <= '{pc: enq0_pc, inst: enq0_inst};
            end
            if (!flush && n_enq == CntW'(2)) begin
                mem_q[tail_nx] <= '{pc: enq1_pc, inst: enq1_inst};
            end
        end
    end

    assign head0      = mem_q[head_q];
    assign head1      = mem_q[head_nx];
    assign count      = count_q;
    assign head0_pc   = head0.pc;
    assign head0_inst = head0.inst;
    assign head1_pc   = head1.pc;
    assign head1_inst = head1.inst;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: drives two consecutive imem addresses per cycle, queues the
// returned words and presents up to two in-order instructions to decode.
module ifetch_ctrl #(
    parameter int unsigned QDEPTH    = ifetch_pkg::QDEPTH,
    parameter int unsigned MEM_WORDS = ifetch_pkg::MEM_WORDS,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr0,
    output logic [31:0] imem_addr1,
    input  logic [31:0] imem_rd0,
    input  logic [31:0] imem_rd1,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [1:0]  pop,
    output logic        out_valid0,
    output logic [31:0] out_inst0,
    output logic [31:0] out_pc0,
    output logic        out_valid1,
    output logic [31:0] out_inst1,
    output logic [31:0] out_pc1
);

    import ifetch_pkg::*;

    localparam int unsigned PcW  = $clog2(MEM_WORDS);
    localparam int unsigned CntW = $clog2(QDEPTH) + 1;

    logic [PcW-1:0]  pc_q, pc_d, pc_inc1, pc_inc2;
    logic [CntW-1:0] count, free;
    logic [1:0]      enq_cnt;
    logic            flush;
    logic            unused_redirect_hi;

    // PC arithmetic is held at PcW bits so it wraps modulo MEM_WORDS for free
    assign pc_inc1    = pc_q + PcW'(1);
    assign pc_inc2    = pc_q + PcW'(2);
    assign imem_addr0 = 32'(pc_q);
    assign imem_addr1 = 32'(pc_inc1);

    assign unused_redirect_hi = ^redirect_pc[31:PcW];

    // Free slots come from the registered count, so pop never feeds the fetch decision
    always_comb begin
        free    = CntW'(QDEPTH) - count;
        flush   = 1'b0;
        enq_cnt = POP_NONE;
        pc_d    = pc_q;
        if (redirect_valid) begin
            flush = 1'b1;
            pc_d  = redirect_pc[PcW-1:0];
        end else if (!halt) begin
            if (free >= CntW'(2)) begin
                enq_cnt = POP_TWO;
                pc_d    = pc_inc2;
            end else if (free == CntW'(1)) begin
                enq_cnt = POP_ONE;
                pc_d    = pc_inc1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PcW'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .enq_cnt    (enq_cnt),
        .enq0_pc    (32'(pc_q)),
        .enq0_inst  (imem_rd0),
        .enq1_pc    (32'(pc_inc1)),
        .enq1_inst  (imem_rd1),
        .deq_cnt    (pop),
        .count      (count),
        .head0_pc   (out_pc0),
        .head0_inst (out_inst0),
        .head1_pc   (out_pc1),
        .head1_inst (out_inst1)
    );

    assign out_valid0 = (count >= CntW'(1));
    assign out_valid1 = (count >= CntW'(2));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model of the fetch rules.
module tb_ifetch_ctrl;

    localparam int MW = 64;
    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr0, imem_addr1, imem_rd0, imem_rd1;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [1:0]  pop = '0;
    logic        out_valid0, out_valid1;
    logic [31:0] out_inst0, out_pc0, out_inst1, out_pc1;

    logic [31:0] mem [MW];
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    int          mpc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign imem_rd0 = mem[imem_addr0[5:0]];
    assign imem_rd1 = mem[imem_addr1[5:0]];

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .QDEPTH    (QD),
        .MEM_WORDS (MW),
        .RESET_PC  (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr0     (imem_addr0),
        .imem_addr1     (imem_addr1),
        .imem_rd0       (imem_rd0),
        .imem_rd1       (imem_rd1),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pop            (pop),
        .out_valid0     (out_valid0),
        .out_inst0      (out_inst0),
        .out_pc0        (out_pc0),
        .out_valid1     (out_valid1),
        .out_inst1      (out_inst1),
        .out_pc1        (out_pc1)
    );

    // Apply one cycle of inputs, advance the model across the edge, sample #1 after it
    task automatic step(input int p, input bit h, input bit rv, input logic [31:0] rpc);
        int free;
        int nenq;
        pop = 2'(p);
        halt = h;
        redirect_valid = rv;
        redirect_pc = rpc;
        if (rv) begin
            q_pc.delete();
            q_inst.delete();
            mpc = int'(rpc % MW);
        end else begin
            assert (p <= q_pc.size()) else $error("pop beyond valid entries");
            free = QD - q_pc.size();
            repeat (p) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            nenq = h ? 0 : ((free >= 2) ? 2 : free);
            for (int k = 0; k < nenq; k++) begin
                q_pc.push_back(32'((mpc + k) % MW));
                q_inst.push_back(mem[(mpc + k) % MW]);
            end
            mpc = (mpc + nenq) % MW;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_inst.delete();
        mpc = 0;
    endtask

    task automatic test_reset();
        logic [195:0] got;
        for (int i = 0; i < MW; i++) mem[i] = 32'(i);
        model_reset();
        #12;
        got = {out_valid0, out_valid1, out_pc0, out_inst0, out_pc1, out_inst1, imem_addr0, imem_addr1};
        n_cmp++;
        if (got !== {2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1}) begin
            n_bad++;
            $display("FAIL reset_state: got %h want v=00 data=0 addr0=0 addr1=1", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        step(0, 0, 0, 0);
        n_cmp++;
        if ({out_valid0, out_valid1, out_pc0, out_pc1, imem_addr0} !== {2'b11, 32'd0, 32'd1, 32'd2}) begin
            n_bad++;
            $display("FAIL fill_first: got v=%b%b pc0=%0d pc1=%0d addr0=%0d want v=11 pc0=0 pc1=1 addr0=2",
                     out_valid0, out_valid1, out_pc0, out_pc1, imem_addr0);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if ({out_pc0, out_inst1, imem_addr0} !== {32'd0, 32'd1, 32'd4}) begin
            n_bad++;
            $display("FAIL fill_second: got pc0=%0d inst1=%0d addr0=%0d want 0 1 4",
                     out_pc0, out_inst1, imem_addr0);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if ({imem_addr0, imem_addr1, out_pc0} !== {32'd4, 32'd5, 32'd0}) begin
            n_bad++;
            $display("FAIL fill_hold: got addr0=%0d addr1=%0d pc0=%0d want 4 5 0",
                     imem_addr0, imem_addr1, out_pc0);
        end
    endtask

    task automatic test_steady();
        for (int i = 0; i < 8; i++) begin
            step(2, 0, 0, 0);
            n_cmp++;
            if ({out_valid0, out_valid1, out_pc0, out_inst0} !==
                {2'b11, 32'(2 * (i + 1)), 32'(2 * (i + 1))}) begin
                n_bad++;
                $display("FAIL steady_pc0[%0d]: got v=%b%b pc0=%0d inst0=%0d want v=11 pc0=inst0=%0d",
                         i, out_valid0, out_valid1, out_pc0, out_inst0, 2 * (i + 1));
            end
        end
    endtask

    task automatic test_partial();
        int a;
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        a = mpc;
        step(0, 0, 0, 0);
        n_cmp++;
        if ({imem_addr0, out_pc0, out_valid1} !== {32'((a + 1) % MW), q_pc[0], 1'b1}) begin
            n_bad++;
            $display("FAIL partial_single: got addr0=%0d pc0=%0d v1=%b want addr0=%0d pc0=%0d v1=1",
                     imem_addr0, out_pc0, out_valid1, (a + 1) % MW, q_pc[0]);
        end
        step(1, 0, 0, 0);
        n_cmp++;
        if ({imem_addr0, out_pc0, out_pc1} !== {32'((a + 1) % MW), q_pc[0], q_pc[1]}) begin
            n_bad++;
            $display("FAIL partial_full_noenq: got addr0=%0d pc0=%0d pc1=%0d want %0d %0d %0d",
                     imem_addr0, out_pc0, out_pc1, (a + 1) % MW, q_pc[0], q_pc[1]);
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 4 && q_pc.size() < QD; i++) step(0, 0, 0, 0);
        step(2, 1, 1, 32'd40);
        n_cmp++;
        if ({out_valid0, out_valid1, imem_addr0, imem_addr1} !== {2'b00, 32'd40, 32'd41}) begin
            n_bad++;
            $display("FAIL redirect_flush: got v=%b%b addr0=%0d addr1=%0d want v=00 40 41",
                     out_valid0, out_valid1, imem_addr0, imem_addr1);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if ({out_valid0, out_pc0, out_inst0, out_pc1} !== {1'b1, 32'd40, 32'd40, 32'd41}) begin
            n_bad++;
            $display("FAIL redirect_target: got v0=%b pc0=%0d inst0=%0d pc1=%0d want 1 40 40 41",
                     out_valid0, out_pc0, out_inst0, out_pc1);
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 32'h0000_ff3f);
        n_cmp++;
        if ({imem_addr0, imem_addr1} !== {32'd63, 32'd0}) begin
            n_bad++;
            $display("FAIL wrap_addr: got addr0=%0d addr1=%0d want 63 0", imem_addr0, imem_addr1);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if ({out_pc0, out_pc1, out_inst1, imem_addr0} !== {32'd63, 32'd0, 32'd0, 32'd1}) begin
            n_bad++;
            $display("FAIL wrap_out: got pc0=%0d pc1=%0d inst1=%0d addr0=%0d want 63 0 0 1",
                     out_pc0, out_pc1, out_inst1, imem_addr0);
        end
    endtask

    task automatic test_halt_reset();
        int a;
        for (int i = 0; i < 4 && q_pc.size() < QD; i++) step(0, 0, 0, 0);
        a = mpc;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            n_cmp++;
            if ({out_valid0, out_valid1, imem_addr0, out_pc0} !==
                {1'b1, (i < 2), 32'(a), q_pc[0]}) begin
                n_bad++;
                $display("FAIL halt_pop[%0d]: got v=%b%b addr0=%0d pc0=%0d want v=1%b addr0=%0d pc0=%0d",
                         i, out_valid0, out_valid1, imem_addr0, out_pc0, (i < 2), a, q_pc[0]);
            end
        end
        pop = 2'd0;
        halt = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({out_valid0, out_valid1, out_pc0, out_inst0, imem_addr0} !== {2'b00, 32'd0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b%b pc0=%0d inst0=%0d addr0=%0d want all 0",
                     out_valid0, out_valid1, out_pc0, out_inst0, imem_addr0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        n_cmp++;
        if ({out_valid0, out_pc0, out_inst1, imem_addr0} !== {1'b1, 32'd0, 32'd1, 32'd2}) begin
            n_bad++;
            $display("FAIL restart: got v0=%b pc0=%0d inst1=%0d addr0=%0d want 1 0 1 2",
                     out_valid0, out_pc0, out_inst1, imem_addr0);
        end
    endtask

    task automatic test_random();
        int p;
        bit h;
        bit rv;
        logic [31:0] e0_pc, e0_inst, e1_pc, e1_inst;
        for (int i = 0; i < MW; i++) mem[i] = $urandom;
        step(0, 0, 1, $urandom);
        for (int c = 0; c < 300; c++) begin
            rv = ($urandom_range(0, 15) == 0);
            h  = ($urandom_range(0, 3) == 0);
            p  = $urandom_range(0, (q_pc.size() < 2) ? q_pc.size() : 2);
            step(p, h, rv, $urandom);
            n_cmp++;
            if ({out_valid0, out_valid1} !== {q_pc.size() >= 1, q_pc.size() >= 2}) begin
                n_bad++;
                $display("FAIL rand_valid[%0d]: got %b%b want %b%b", c, out_valid0, out_valid1,
                         q_pc.size() >= 1, q_pc.size() >= 2);
            end
            e0_pc   = (q_pc.size() >= 1) ? q_pc[0] : out_pc0;
            e0_inst = (q_pc.size() >= 1) ? q_inst[0] : out_inst0;
            e1_pc   = (q_pc.size() >= 2) ? q_pc[1] : out_pc1;
            e1_inst = (q_pc.size() >= 2) ? q_inst[1] : out_inst1;
            if (q_pc.size() >= 1) begin
                n_cmp++;
                if ({out_pc0, out_inst0, out_pc1, out_inst1} !== {e0_pc, e0_inst, e1_pc, e1_inst}) begin
                    n_bad++;
                    $display("FAIL rand_data[%0d]: got %0d/%h %0d/%h want %0d/%h %0d/%h", c,
                             out_pc0, out_inst0, out_pc1, out_inst1, e0_pc, e0_inst, e1_pc, e1_inst);
                end
            end
            n_cmp++;
            if ({imem_addr0, imem_addr1} !== {32'(mpc), 32'((mpc + 1) % MW)}) begin
                n_bad++;
                $display("FAIL rand_addr[%0d]: got %0d %0d want %0d %0d", c, imem_addr0, imem_addr1,
                         mpc, (mpc + 1) % MW);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_steady();
        test_partial();
        test_redirect();
        test_wrap();
        test_halt_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
